harmonic_mixer: RTL and testbench
=================================

HARMONIC_MIXER -- requirements
Module: harmonic_mixer

Interface
REQ-001 SHALL have parameter NUM_HARM, default 15; number of phasor inputs, legal range 1..15.
REQ-002 SHALL have parameter SHIFT, default 4; arithmetic right shift applied to the sum before narrowing, legal range 0..8.
REQ-003 SHALL have port clk, input, 1; clock.
REQ-004 SHALL have port reset, input, 1; reset, synchronous, active-high.
REQ-005 SHALL have port sample_tick, input, 1; one-cycle pulse requesting one audio sample.
REQ-006 SHALL have port harm_in, input, NUM_HARM x 20 signed; phasor outputs, 4.16 fixed point.
REQ-007 SHALL have port harm_en, input, NUM_HARM; per-harmonic enable mask.
REQ-008 SHALL have port out_data, output, 16 signed; mixed sample.
REQ-009 SHALL have port out_valid, output, 1; out_data holds a valid sample.
REQ-010 SHALL have port out_ready, input, 1; consumer accepts the sample.
REQ-011 SHALL have port busy, output, 1; high in any state other than IDLE.
REQ-012 SHALL have port overrun, output, 1; one-cycle pulse when a sample is dropped.

Function
REQ-013 SHALL implement FSM states IDLE, ACCUM and SCALE.
REQ-014 SHALL, in IDLE with sample_tick high, capture all harm_in and harm_en into snapshot registers, clear acc and idx, and go to ACCUM.
REQ-015 SHALL, in ACCUM, add snap[idx] to acc each cycle if en[idx] is set (else add 0), increment idx, and go to SCALE after NUM_HARM cycles.
REQ-016 SHALL size acc at 20+clog2(NUM_HARM) bits signed (24 for NUM_HARM=15) so the sum cannot overflow.
REQ-017 SHALL, in SCALE, compute acc >>> SHIFT, narrow it to 16 bits per REQ-027, push the result into the output FIFO, and return to IDLE.
REQ-018 SHALL deliver latency such that out_valid rises exactly NUM_HARM+2 cycles after the edge sampling sample_tick (17 at default), with the FIFO empty and out_ready high.
REQ-019 SHALL use a 2-entry output FIFO; out_valid = not empty; pop when out_valid and out_ready are both high; out_data = head entry, held stable while out_valid is high and out_ready is low.
REQ-020 SHALL accept a push when the FIFO is full and a pop occurs in the same cycle.
REQ-021 SHALL, when pushing to a full FIFO with no pop, drop the new sample, leave the FIFO unchanged and pulse overrun.
REQ-022 SHALL ignore sample_tick in ACCUM or SCALE, pulse overrun, and leave the current sample unaffected.
REQ-023 SHALL pulse overrun once when REQ-021 and REQ-022 occur in the same cycle.
REQ-024 SHALL ensure harm_in changes after capture do not affect the sample in progress.

Reset
REQ-025 SHALL, on reset, put the FSM in IDLE and clear acc, idx, snapshots and FIFO pointers, with out_valid=0, out_data=0, busy=0 and overrun=0.
REQ-026 SHALL, on reset mid-ACCUM or mid-SCALE, discard the partial sample with no push and no output; a sample_tick in the reset cycle is ignored.

Configuration
REQ-027 SHALL, with HARMONIC_MIXER_SAT_EN defined, clamp the shifted value to [-32768, 32767]; without it, keep the low 16 bits (two's-complement wrap).

Structure
REQ-028 SHALL place the state enum, SAMPLE_W=20, OUT_W=16 and an ACC_W(n) function in package harmonic_mixer_pkg.
REQ-029 SHALL implement the FIFO as sub-module mixer_out_fifo (2 entries, OUT_W wide, push/pop/full/empty).

Verification
REQ-030 SHALL verify accumulation: all harm_in=16, harm_en all ones, SHIFT=4, tick -> out_data=15, out_valid at cycle 17.
REQ-031 SHALL verify the enable mask: harm_in[k]=k*16, harm_en=0x0005 (harmonics 0 and 2), SHIFT=4 -> out_data=2.
REQ-032 SHALL verify saturation: SHIFT=2, only harm_in[0]=0x7FFFF enabled -> out_data=32767 with the macro, -1 without; only harm_in[0]=0x80000 enabled -> -32768 with the macro, 0 without.
REQ-033 SHALL verify backpressure: out_ready=0, three ticks spaced 20 cycles apart -> first two samples held in order, overrun pulses once on the third push, out_ready=1 -> two pops.
REQ-034 SHALL verify tick-while-busy: second tick 5 cycles after the first -> overrun pulses for 1 cycle, exactly one sample produced.
REQ-035 SHALL verify reset mid-operation: reset asserted at cycle 8 of ACCUM -> no sample produced, busy=0 the next cycle, a fresh tick then gives a correct result.

Source files
------------

// File: rtl/harmonic_mixer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : harmonic_mixer_pkg
// Description : Shared types and constants for the harmonic mixer: sample and
//               output widths, FSM state encoding and the accumulator-width
//               helper. Build option HARMONIC_MIXER_SAT_EN (see harmonic_mixer).
// Revision    : 1.0 - initial release
// ============================================================================
package harmonic_mixer_pkg;

  localparam int SAMPLE_W = 20;  // phasor sample width, 4.16 fixed point
  localparam int OUT_W    = 16;  // mixed audio sample width

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_SCALE = 2'd2
  } state_e;

  // Enough headroom that summing n full-scale samples cannot overflow.
  function automatic int ACC_W(input int n);
    return SAMPLE_W + $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mixer_out_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mixer_out_fifo
// Description : Two-entry output FIFO. A push into a full FIFO is accepted only
//               when a pop happens in the same cycle; otherwise it is dropped.
// Ports       : clk, reset      - clock, synchronous active-high reset
//               push, push_data - write request and data
//               pop             - read request (ignored when empty)
//               rd_data         - head entry
//               full, empty     - occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module mixer_out_fifo
  import harmonic_mixer_pkg::*;
#(
  parameter int WIDTH = OUT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == 2'd2);
  assign empty   = (count_q == 2'd0);
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/harmonic_mixer.sv
`default_nettype none
// ============================================================================
// Module      : harmonic_mixer
// Description : On each sample_tick, snapshots NUM_HARM phasor values and an
//               enable mask, sums the enabled ones serially (one per cycle),
//               scales by an arithmetic right shift of SHIFT and narrows the
//               result to 16 bits into a 2-entry output FIFO.
//               Build option HARMONIC_MIXER_SAT_EN: saturate when narrowing
//               (default build wraps to the low 16 bits).
// Ports       : clk, reset  - clock, synchronous active-high reset
//               sample_tick - request one sample (ignored while busy)
//               harm_in     - NUM_HARM signed 20-bit phasor samples
//               harm_en     - per-harmonic enable mask
//               out_data    - FIFO head sample; out_valid - FIFO not empty
//               out_ready   - consumer pops the head when valid
//               busy        - FSM not idle
//               overrun     - one-cycle pulse when a tick or sample is lost
// Revision    : 1.0 - initial release
// ============================================================================
module harmonic_mixer
  import harmonic_mixer_pkg::*;
#(
  parameter int NUM_HARM = 15,
  parameter int SHIFT    = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               sample_tick,
  input  logic [NUM_HARM-1:0][SAMPLE_W-1:0]  harm_in,
  input  logic [NUM_HARM-1:0]                harm_en,
  output logic signed [OUT_W-1:0]            out_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               busy,
  output logic                               overrun
);

  localparam int                AW       = ACC_W(NUM_HARM);
  localparam int                IDX_W    = (NUM_HARM > 1) ? $clog2(NUM_HARM) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_HARM - 1);

  state_e                             state_q, state_d;
  logic signed [AW-1:0]               acc_q, acc_d;
  logic [IDX_W-1:0]                   idx_q, idx_d;
  logic [NUM_HARM-1:0][SAMPLE_W-1:0]  snap_q, snap_d;
  logic [NUM_HARM-1:0]                en_q, en_d;
  // The scaled result is staged one cycle before entering the FIFO, which
  // sets the tick-to-valid latency to NUM_HARM+2.
  logic                               push_q, push_d;
  logic [OUT_W-1:0]                   push_data_q, push_data_d;
  logic                               overrun_q, overrun_d;
  logic                               tick_busy;
  logic [OUT_W-1:0]                   narrowed;
  logic                               fifo_full, fifo_empty, fifo_pop;
  logic [OUT_W-1:0]                   fifo_rd_data;

`ifdef HARMONIC_MIXER_SAT_EN
  localparam logic signed [AW-1:0] SAT_HI = AW'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [AW-1:0] SAT_LO = AW'(-(1 << (OUT_W - 1)));
  logic signed [AW-1:0] shifted;

  always_comb begin
    shifted = acc_q >>> SHIFT;
    if (shifted > SAT_HI) begin
      narrowed = {1'b0, {(OUT_W-1){1'b1}}};
    end else if (shifted < SAT_LO) begin
      narrowed = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      narrowed = shifted[OUT_W-1:0];
    end
  end
`else
  assign narrowed = OUT_W'(acc_q >>> SHIFT);
`endif

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    snap_d      = snap_q;
    en_d        = en_q;
    push_d      = 1'b0;
    push_data_d = push_data_q;
    tick_busy   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sample_tick) begin
          snap_d  = harm_in;
          en_d    = harm_en;
          acc_d   = '0;
          idx_d   = '0;
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        tick_busy = sample_tick;
        if (en_q[idx_q]) begin
          acc_d = acc_q + AW'($signed(snap_q[idx_q]));
        end
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = ST_SCALE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_SCALE: begin
        tick_busy   = sample_tick;
        push_d      = 1'b1;
        push_data_d = narrowed;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // A dropped push and an ignored tick in the same cycle give one pulse.
    overrun_d = tick_busy | (push_q & fifo_full & ~fifo_pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      idx_q       <= '0;
      snap_q      <= '0;
      en_q        <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      snap_q      <= snap_d;
      en_q        <= en_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
      overrun_q   <= overrun_d;
    end
  end

  assign fifo_pop = ~fifo_empty & out_ready;

  mixer_out_fifo #(
    .WIDTH (OUT_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_q),
    .push_data (push_data_q),
    .pop       (fifo_pop),
    .rd_data   (fifo_rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign out_data  = $signed(fifo_rd_data);
  assign out_valid = ~fifo_empty;
  assign busy      = (state_q != ST_IDLE);
  assign overrun   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_harmonic_mixer.sv
`default_nettype none
// ============================================================================
// Module      : tb_harmonic_mixer
// Description : Self-checking bench for harmonic_mixer. Two instances share
//               stimulus: SHIFT=4 (default) and SHIFT=2. Expected samples are
//               queued when a tick is issued and compared on each pop.
//               Expectations follow HARMONIC_MIXER_SAT_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_harmonic_mixer;

  localparam int NH = 15;

  logic                clk = 1'b0;
  logic                reset;
  logic                sample_tick;
  logic [NH-1:0][19:0] harm_in;
  logic [NH-1:0]       harm_en;
  logic                out_ready;
  logic signed [15:0]  out_data, out_data2;
  logic                out_valid, out_valid2;
  logic                busy, busy2;
  logic                overrun, overrun2;

  always #5 clk = ~clk;

  harmonic_mixer #(.NUM_HARM(NH), .SHIFT(4)) dut (
    .clk(clk), .reset(reset), .sample_tick(sample_tick), .harm_in(harm_in),
    .harm_en(harm_en), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .overrun(overrun)
  );

  harmonic_mixer #(.NUM_HARM(NH), .SHIFT(2)) dut2 (
    .clk(clk), .reset(reset), .sample_tick(sample_tick), .harm_in(harm_in),
    .harm_en(harm_en), .out_data(out_data2), .out_valid(out_valid2),
    .out_ready(out_ready), .busy(busy2), .overrun(overrun2)
  );

  typedef struct {
    logic [19:0] base;
    logic [19:0] step;
    logic [14:0] en;
    int          e4w, e4s, e2w, e2s;  // expected: SHIFT=4/2, wrap/sat
  } vec_t;

  vec_t vecs [8];
  int   q4 [$];
  int   q2 [$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   pops4    = 0;
  int   pops2    = 0;
  int   ovr_cnt  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int exp4(input int i);
`ifdef HARMONIC_MIXER_SAT_EN
    return vecs[i].e4s;
`else
    return vecs[i].e4w;
`endif
  endfunction

  function automatic int exp2(input int i);
`ifdef HARMONIC_MIXER_SAT_EN
    return vecs[i].e2s;
`else
    return vecs[i].e2w;
`endif
  endfunction

  // Scoreboard side: compare every sample popped by the consumer.
  always @(negedge clk) begin
    if (!reset) begin
      if (overrun) ovr_cnt++;
      if (out_valid && out_ready) begin
        pops4++;
        if (q4.size() == 0) check("unexpected_pop4", int'(out_data), -99999);
        else check("sample4", int'(out_data), q4.pop_front());
      end
      if (out_valid2 && out_ready) begin
        pops2++;
        if (q2.size() == 0) check("unexpected_pop2", int'(out_data2), -99999);
        else check("sample2", int'(out_data2), q2.pop_front());
      end
    end
  end

  task automatic load_vec(input int i);
    for (int k = 0; k < NH; k++) harm_in[k] = vecs[i].base + 20'(k) * vecs[i].step;
    harm_en = vecs[i].en;
  endtask

  // Pulse sample_tick for one cycle; returns just after the sampling edge.
  task automatic tick_once();
    @(posedge clk); #1 sample_tick = 1'b1;
    @(posedge clk); #1 sample_tick = 1'b0;
  endtask

  task automatic run_row(input int i);
    int lat;
    load_vec(i);
    q4.push_back(exp4(i));
    q2.push_back(exp2(i));
    tick_once();
    for (int k = 0; k < NH; k++) harm_in[k] = 20'($urandom);
    harm_en = 15'($urandom);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    check($sformatf("latency_row%0d", i), lat, 17);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation timed out, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, o0;
    //            base        step      en        e4w     e4s     e2w     e2s
    vecs[0] = '{20'h00010, 20'h00000, 15'h7FFF,     15,     15,     60,     60};
    vecs[1] = '{20'h00000, 20'h00010, 15'h0005,      2,      2,      8,      8};
    vecs[2] = '{20'h7FFFF, 20'h00000, 15'h0001,  32767,  32767,     -1,  32767};
    vecs[3] = '{20'h80000, 20'h00000, 15'h0001, -32768, -32768,      0, -32768};
    vecs[4] = '{20'hFFFF0, 20'h00000, 15'h7FFF,    -15,    -15,    -60,    -60};
    vecs[5] = '{20'h12345, 20'h00111, 15'h0000,      0,      0,      0,      0};
    vecs[6] = '{20'h7FFFF, 20'h00000, 15'h7FFF,  32767,  32767,     -4,  32767};
    vecs[7] = '{20'h00000, 20'h00001, 15'h7FFF,      6,      6,     26,     26};

    reset = 1'b1; sample_tick = 1'b0; out_ready = 1'b1;
    harm_in = '0; harm_en = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out_data", int'(out_data), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_overrun", int'(overrun), 0);

    for (int i = 0; i < 8; i++) run_row(i);

    // Backpressure: two samples held in order, third dropped with one overrun.
    out_ready = 1'b0;
    o0 = ovr_cnt; p0 = pops4;
    q4.push_back(exp4(0)); q2.push_back(exp2(0));
    load_vec(0); tick_once(); repeat (19) @(posedge clk);
    q4.push_back(exp4(1)); q2.push_back(exp2(1));
    load_vec(1); tick_once(); repeat (19) @(posedge clk);
    load_vec(7); tick_once();
    repeat (30) @(posedge clk);
    @(negedge clk);
    check("bp_overrun_count", ovr_cnt - o0, 1);
    check("bp_hold_valid", int'(out_valid), 1);
    check("bp_hold_data", int'(out_data), exp4(0));
    check("bp_no_pop", pops4 - p0, 0);
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("bp_two_pops", pops4 - p0, 2);
    check("bp_queue_drained", q4.size() + q2.size(), 0);
    check("bp_empty_after", int'(out_valid), 0);

    // Tick while busy: one overrun pulse, exactly one sample.
    o0 = ovr_cnt; p0 = pops4;
    load_vec(7);
    q4.push_back(exp4(7)); q2.push_back(exp2(7));
    tick_once();
    repeat (4) @(posedge clk);
    #1 sample_tick = 1'b1;
    @(posedge clk); #1 sample_tick = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk);
    check("busy_tick_overrun", ovr_cnt - o0, 1);
    check("busy_tick_one_sample", pops4 - p0, 1);

    // Reset at cycle 8 of ACCUM, with a tick in the reset cycle.
    p0 = pops4;
    load_vec(0);
    tick_once();
    repeat (7) @(posedge clk);
    #1 reset = 1'b1; sample_tick = 1'b1;
    @(posedge clk); #1 reset = 1'b0; sample_tick = 1'b0;
    check("rst_busy_after", int'(busy), 0);
    repeat (30) @(posedge clk);
    @(negedge clk);
    check("rst_no_sample", pops4 - p0, 0);
    check("rst_no_valid", int'(out_valid), 0);
    run_row(1);

    check("final_queue4", q4.size(), 0);
    check("final_queue2", q2.size(), 0);
    check("final_pop_match", pops4, pops2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
